combo_dialer: RTL and testbench

//  Drives the combo lock's keypad side: takes a BCD code and sends it as one-hot key presses,

---
 rtl/combo_dialer_pkg.sv | 38 +++
 rtl/combo_dialer_if.sv | 38 +++
 rtl/combo_dialer_bcd_to_onehot.sv | 25 ++
 rtl/combo_dialer.sv | 192 +++++++++++++++++++
 tb/tb_combo_dialer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/combo_dialer_pkg.sv
`default_nettype none
// ============================================================================
// combo_dialer_pkg : shared types and widths for the combo lock keypad dialer
// Revision: 1.0
// ============================================================================
package combo_dialer_pkg;

    localparam int KEYPAD_W = 10;
    localparam int BCD_W    = 4;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PREP      = 4'd1,
        S_PREP_GAP  = 4'd2,
        S_PRESS     = 4'd3,
        S_GAP       = 4'd4,
        S_ENTER     = 4'd5,
        S_ENTER_GAP = 4'd6,
        S_WAIT_RESP = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        V_NONE    = 3'd0,
        V_PASS    = 3'd1,
        V_FAIL    = 3'd2,
        V_TIMEOUT = 3'd3,
        V_BAD     = 3'd4
    } verdict_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/combo_dialer_if.sv
`default_nettype none
// ============================================================================
// combo_dialer_if : request/verdict/keypad bundle between controller, dialer, lock
// Revision: 1.0
// ============================================================================
interface combo_dialer_if
    import combo_dialer_pkg::*;
#(
    parameter int DIGITS = 4
);
    // prog selects reprogramming (1) versus an unlock attempt (0)
    logic                      start;
    logic                      prog;
    logic [BCD_W*DIGITS-1:0]   code;
    logic                      unlock;
    logic                      incorrect;
    logic [KEYPAD_W-1:0]       keypad;
    logic                      enter;
    logic                      clr;
    logic                      lock_rst;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic                      fail;
    logic                      timeout;
    logic                      bad_code;

    modport master (
        output start, prog, code, unlock, incorrect,
        input  keypad, enter, clr, lock_rst, busy, done, pass, fail, timeout, bad_code
    );

    modport slave (
        input  start, prog, code, unlock, incorrect,
        output keypad, enter, clr, lock_rst, busy, done, pass, fail, timeout, bad_code
    );
endinterface
`default_nettype wire

// File: rtl/combo_dialer_bcd_to_onehot.sv
`default_nettype none
// ============================================================================
// combo_dialer_bcd_to_onehot : one BCD digit to a one-hot key, flags non-decimal
// Revision: 1.0
// ============================================================================
module combo_dialer_bcd_to_onehot
    import combo_dialer_pkg::*;
(
    input  wire logic [BCD_W-1:0]    bcd,
    output      logic [KEYPAD_W-1:0] onehot,
    output      logic                invalid
);

    always_comb begin
        onehot = '0;
        for (int d = 0; d < KEYPAD_W; d++) begin
            if (bcd == BCD_W'(d)) begin
                onehot[d] = 1'b1;
            end
        end
        invalid = (bcd > BCD_W'(9));
    end

endmodule
`default_nettype wire

// File: rtl/combo_dialer.sv
`default_nettype none
// ============================================================================
// combo_dialer : sends a BCD code to the lock as timed key pulses, reports verdict
// Revision: 1.0
// ============================================================================
module combo_dialer
    import combo_dialer_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESS_CYC    = 1,
    parameter int GAP_CYC      = 1,
    parameter int RESP_TIMEOUT = 8
)(
    input wire logic      clk,
    input wire logic      rst_n,
    combo_dialer_if.slave bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(max3(PRESS_CYC, GAP_CYC, RESP_TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] C_PRESS_LD = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_RESP_LD  = CNT_W'(RESP_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                  r_state, w_state_nxt;
    verdict_t                w_verdict;
    logic [CNT_W-1:0]        r_cnt, w_cnt_ld;
    logic                    w_cnt_zero;
    logic [IDX_W-1:0]        r_idx, w_idx_nxt;
    logic [BCD_W*DIGITS-1:0] r_code;
    logic                    r_prog, w_prog_nxt;
    logic [DIGITS-1:0]       w_dig_bad;
    logic                    w_any_bad;
    logic [BCD_W-1:0]        w_digits [DIGITS];
    logic [KEYPAD_W-1:0]     w_drive_onehot;
    logic                    w_drive_inv;

    logic [KEYPAD_W-1:0]     w_keypad_nxt;
    logic                    w_enter_nxt, w_clr_nxt, w_lock_rst_nxt, w_busy_nxt;
    logic                    w_done_nxt, w_pass_nxt, w_fail_nxt, w_timeout_nxt, w_bad_nxt;

    // Live code is checked so a bad digit aborts on the start edge itself.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_check
            logic [KEYPAD_W-1:0] w_oh;
            logic                w_inv;
            combo_dialer_bcd_to_onehot u_chk (
                .bcd     (bus.code[g*BCD_W +: BCD_W]),
                .onehot  (w_oh),
                .invalid (w_inv)
            );
            assign w_dig_bad[g] = w_inv | ~(|w_oh);
            assign w_digits[g]  = r_code[(DIGITS-1-g)*BCD_W +: BCD_W];
        end
    endgenerate

    assign w_any_bad  = |w_dig_bad;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_prog_nxt = (r_state == S_IDLE) ? bus.prog : r_prog;
    assign w_idx_nxt  = (r_state == S_IDLE) ? '0 :
                        (r_state == S_GAP && w_state_nxt == S_PRESS) ? r_idx + 1'b1 : r_idx;

    combo_dialer_bcd_to_onehot u_drive (
        .bcd     (w_digits[w_idx_nxt]),
        .onehot  (w_drive_onehot),
        .invalid (w_drive_inv)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_verdict   = V_NONE;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_any_bad) begin
                        w_state_nxt = S_FINISH;
                        w_verdict   = V_BAD;
                    end else if (bus.prog && !bus.unlock) begin
                        w_state_nxt = S_FINISH;
                        w_verdict   = V_FAIL;
                    end else begin
                        w_state_nxt = S_PREP;
                    end
                end
            end
            S_PREP:     if (w_cnt_zero) w_state_nxt = S_PREP_GAP;
            S_PREP_GAP: if (w_cnt_zero) w_state_nxt = S_PRESS;
            S_PRESS:    if (w_cnt_zero) w_state_nxt = S_GAP;
            S_GAP:      if (w_cnt_zero) w_state_nxt = (r_idx == C_LAST_IDX) ? S_ENTER : S_PRESS;
            S_ENTER:    if (w_cnt_zero) w_state_nxt = S_ENTER_GAP;
            S_ENTER_GAP: begin
                if (w_cnt_zero) begin
                    if (r_prog) begin
                        w_state_nxt = S_FINISH;
                        w_verdict   = V_PASS;
                    end else begin
                        w_state_nxt = S_WAIT_RESP;
                    end
                end
            end
            S_WAIT_RESP: begin
                // incorrect has priority when the lock reports both
                if (bus.incorrect) begin
                    w_state_nxt = S_FINISH;
                    w_verdict   = V_FAIL;
                end else if (bus.unlock) begin
                    w_state_nxt = S_FINISH;
                    w_verdict   = V_PASS;
                end else if (w_cnt_zero) begin
                    w_state_nxt = S_FINISH;
                    w_verdict   = V_TIMEOUT;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (w_state_nxt)
            S_PREP, S_PRESS, S_ENTER:         w_cnt_ld = C_PRESS_LD;
            S_PREP_GAP, S_GAP, S_ENTER_GAP:   w_cnt_ld = C_GAP_LD;
            S_WAIT_RESP:                      w_cnt_ld = C_RESP_LD;
            default:                          w_cnt_ld = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_code <= '0;
            r_prog <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)  r_cnt <= w_cnt_ld;
            else if (!w_cnt_zero)        r_cnt <= r_cnt - 1'b1;
            r_idx <= w_idx_nxt;
            if (r_state == S_IDLE && bus.start) begin
                r_code <= bus.code;
                r_prog <= bus.prog;
            end
        end
    end

    // Outputs are decoded from the next state so registered values line up with the state.
    always_comb begin
        w_keypad_nxt   = (w_state_nxt == S_PRESS && !w_drive_inv) ? w_drive_onehot : '0;
        w_enter_nxt    = (w_state_nxt == S_ENTER);
        w_clr_nxt      = (w_state_nxt == S_PREP) && !w_prog_nxt;
        w_lock_rst_nxt = (w_state_nxt == S_PREP) && w_prog_nxt;
        w_busy_nxt     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FINISH);
        w_done_nxt     = (w_state_nxt == S_FINISH);
        w_pass_nxt     = w_done_nxt && (w_verdict == V_PASS);
        w_fail_nxt     = w_done_nxt && (w_verdict == V_FAIL);
        w_timeout_nxt  = w_done_nxt && (w_verdict == V_TIMEOUT);
        w_bad_nxt      = w_done_nxt && (w_verdict == V_BAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.keypad   <= '0;
            bus.enter    <= 1'b0;
            bus.clr      <= 1'b0;
            bus.lock_rst <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.fail     <= 1'b0;
            bus.timeout  <= 1'b0;
            bus.bad_code <= 1'b0;
        end else begin
            bus.keypad   <= w_keypad_nxt;
            bus.enter    <= w_enter_nxt;
            bus.clr      <= w_clr_nxt;
            bus.lock_rst <= w_lock_rst_nxt;
            bus.busy     <= w_busy_nxt;
            bus.done     <= w_done_nxt;
            bus.pass     <= w_pass_nxt;
            bus.fail     <= w_fail_nxt;
            bus.timeout  <= w_timeout_nxt;
            bus.bad_code <= w_bad_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_combo_dialer.sv
`default_nettype none
// ============================================================================
// tb_combo_dialer : cycle-by-cycle comparison of combo_dialer against a timeline model
// Revision: 1.0
// ============================================================================
module tb_combo_dialer;

    localparam int DIGITS       = 4;
    localparam int PRESS_CYC    = 1;
    localparam int GAP_CYC      = 1;
    localparam int RESP_TIMEOUT = 8;

    typedef struct packed {
        logic [9:0] keypad;
        logic       enter;
        logic       clr;
        logic       lock_rst;
        logic       busy;
        logic       done;
        logic       pass;
        logic       fail;
        logic       timeout;
        logic       bad_code;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    combo_dialer_if #(.DIGITS(DIGITS)) bus();

    combo_dialer #(
        .DIGITS       (DIGITS),
        .PRESS_CYC    (PRESS_CYC),
        .GAP_CYC      (GAP_CYC),
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         check_en = 1'b0;
    obs_t       exp_cur;
    obs_t       act_now;
    obs_t       act_q [$];
    obs_t       exp_q [$];
    logic [2:0] drv_q [$];   // {verdict noise allowed, unlock, incorrect}

    function automatic obs_t sample();
        obs_t o;
        o.keypad   = bus.keypad;
        o.enter    = bus.enter;
        o.clr      = bus.clr;
        o.lock_rst = bus.lock_rst;
        o.busy     = bus.busy;
        o.done     = bus.done;
        o.pass     = bus.pass;
        o.fail     = bus.fail;
        o.timeout  = bus.timeout;
        o.bad_code = bus.bad_code;
        return o;
    endfunction

    function automatic obs_t mk(input logic [9:0] kp, input logic en, input logic cl,
                                input logic lr, input logic bz, input logic dn,
                                input logic ps, input logic fl, input logic to,
                                input logic bc);
        obs_t o;
        o = {kp, en, cl, lr, bz, dn, ps, fl, to, bc};
        return o;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            act_now = sample();
            act_q.push_back(act_now);
            n_cmp++;
            if (act_now !== exp_cur) begin
                n_bad++;
                $display("FAIL seq_cycle t=%0t: got %h required %h", $time, act_now, exp_cur);
            end
        end
    end

    task automatic chk_cyc(input string name, input int idx, input obs_t req);
        obs_t a;
        n_cmp++;
        if (idx < act_q.size()) a = act_q[idx];
        else                    a = 'x;
        if (a !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, a, req);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] a, input logic [31:0] r);
        n_cmp++;
        if (a !== r) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, a, r);
        end
    endtask

    task automatic put_n(input obs_t o, input int n, input logic [2:0] d);
        for (int t = 0; t < n; t++) begin
            exp_q.push_back(o);
            drv_q.push_back(d);
        end
    endtask

    // Expected output timeline, one entry per cycle after the start edge.
    // vk: 1 = incorrect, 2 = unlock, 3 = both; vj = WAIT cycle of verdict (0 = none).
    task automatic build(input logic [4*DIGITS-1:0] c, input bit pg, input bit ul,
                         input int vj, input int vk);
        obs_t       o;
        obs_t       busy_only;
        bit         bad;
        logic [3:0] dg;
        logic [2:0] idle_drv;
        exp_q.delete();
        drv_q.delete();
        bad       = 1'b0;
        idle_drv  = {1'b1, pg & ul, 1'b0};
        busy_only = mk(10'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DIGITS; i++)
            if (c[4*i +: 4] > 4'd9) bad = 1'b1;
        if (bad) begin
            put_n(mk(10'h0, 0, 0, 0, 0, 1, 0, 0, 0, 1), 1, idle_drv);
            return;
        end
        if (pg && !ul) begin
            put_n(mk(10'h0, 0, 0, 0, 0, 1, 0, 1, 0, 0), 1, idle_drv);
            return;
        end
        put_n(mk(10'h0, 0, !pg, pg, 1, 0, 0, 0, 0, 0), PRESS_CYC, idle_drv);
        put_n(busy_only, GAP_CYC, idle_drv);
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dg = c[4*i +: 4];
            put_n(mk(10'd1 << dg, 0, 0, 0, 1, 0, 0, 0, 0, 0), PRESS_CYC, idle_drv);
            put_n(busy_only, GAP_CYC, idle_drv);
        end
        put_n(mk(10'h0, 1, 0, 0, 1, 0, 0, 0, 0, 0), PRESS_CYC, idle_drv);
        put_n(busy_only, GAP_CYC, idle_drv);
        if (pg) begin
            put_n(mk(10'h0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1, idle_drv);
            return;
        end
        for (int j = 1; j <= RESP_TIMEOUT; j++) begin
            if (j == vj) begin
                put_n(busy_only, 1, {1'b0, vk[1], vk[0]});
                o = mk(10'h0, 0, 0, 0, 0, 1, !vk[0], vk[0], 0, 0);
                put_n(o, 1, 3'b100);
                return;
            end
            put_n(busy_only, 1, 3'b000);
        end
        put_n(mk(10'h0, 0, 0, 0, 0, 1, 0, 0, 1, 0), 1, 3'b100);
    endtask

    task automatic run(input logic [4*DIGITS-1:0] c, input bit pg, input bit ul,
                       input int vj, input int vk, input bit noisy);
        build(c, pg, ul, vj, vk);
        @(posedge clk); #1;
        act_q.delete();
        exp_cur       = '0;
        check_en      = 1'b1;
        bus.code      = c;
        bus.prog      = pg;
        bus.unlock    = pg & ul;
        bus.incorrect = 1'b0;
        bus.start     = 1'b1;
        foreach (exp_q[k]) begin
            @(posedge clk); #1;
            exp_cur   = exp_q[k];
            bus.start = noisy ? 1'($urandom_range(1)) : 1'b0;
            if (noisy) begin
                bus.code = 16'($urandom);
                bus.prog = 1'($urandom_range(1));
            end
            if (noisy && drv_q[k][2]) {bus.unlock, bus.incorrect} = 2'($urandom_range(3));
            else                      {bus.unlock, bus.incorrect} = drv_q[k][1:0];
        end
        @(posedge clk); #1;
        exp_cur       = '0;
        bus.start     = 1'b0;
        bus.unlock    = 1'b0;
        bus.incorrect = 1'b0;
        @(negedge clk); #1;
        check_en = 1'b0;
    endtask

    function automatic logic [15:0] rand_code();
        logic [15:0] c;
        logic [3:0]  v;
        for (int i = 0; i < DIGITS; i++) begin
            v = 4'($urandom_range(9));
            if ($urandom_range(7) == 0) v = 4'($urandom_range(15, 10));
            c[4*i +: 4] = v;
        end
        return c;
    endfunction

    initial begin
        bus.start     = 1'b0;
        bus.prog      = 1'b0;
        bus.code      = '0;
        bus.unlock    = 1'b0;
        bus.incorrect = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk_val("reset_state", 32'(sample()), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Unlock attempt accepted on the first verdict cycle
        run(16'h8086, 0, 0, 1, 2, 0);
        chk_cyc("t1_clr",    1,  mk(10'h000, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t1_gap",    2,  mk(10'h000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t1_key8",   3,  mk(10'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t1_key0",   5,  mk(10'h001, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t1_key8b",  7,  mk(10'h100, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t1_key6",   9,  mk(10'h040, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t1_enter",  11, mk(10'h000, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t1_pass",   14, mk(10'h000, 0, 0, 0, 0, 1, 1, 0, 0, 0));

        // Wrong code reported on the second verdict cycle, then both verdicts at once
        run(16'h1234, 0, 0, 2, 1, 0);
        chk_cyc("t2_busy",   14, mk(10'h000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t2_fail",   15, mk(10'h000, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        run(16'h9999, 0, 0, 4, 3, 0);
        chk_cyc("t2_both",   17, mk(10'h000, 0, 0, 0, 0, 1, 0, 1, 0, 0));

        // No verdict at all
        run(16'h0000, 0, 0, 0, 0, 0);
        chk_cyc("t3_wait",   20, mk(10'h000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t3_tmo",    21, mk(10'h000, 0, 0, 0, 0, 1, 0, 0, 1, 0));

        // Non-decimal digit
        run(16'h80A6, 0, 0, 0, 0, 0);
        chk_cyc("t4_bad",    1,  mk(10'h000, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        chk_cyc("t4_idle",   2,  mk(10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Program mode, locked then unlocked
        run(16'h8086, 1, 0, 0, 0, 0);
        chk_cyc("t5_locked", 1,  mk(10'h000, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        run(16'h8086, 1, 1, 0, 0, 0);
        chk_cyc("t5_lrst",   1,  mk(10'h000, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        chk_cyc("t5_key6",   9,  mk(10'h040, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        chk_cyc("t5_pass",   13, mk(10'h000, 0, 0, 0, 0, 1, 1, 0, 0, 0));

        // Asynchronous reset in the middle of a key press
        @(posedge clk); #1;
        bus.code  = 16'h8086;
        bus.prog  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_val("t6_pre_key", 32'(bus.keypad), 32'h100);
        #2 rst_n = 1'b0;
        #1;
        chk_val("t6_rst_keypad", 32'(bus.keypad), 32'h0);
        chk_val("t6_rst_busy",   32'(bus.busy),   32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk_val("t6_idle", 32'(sample()), 32'h0);

        // Randomized traffic with start pulses, code changes and verdict noise while busy
        repeat (60) begin
            run(rand_code(), ($urandom_range(3) == 0), 1'($urandom_range(1)),
                int'($urandom_range(RESP_TIMEOUT)), int'($urandom_range(3, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
